regfile_nrp: RTL and testbench

REGFILE_NRP -- requirements
Module: regfile_nrp

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_nrp_muxn_w.sv | 39 +++
 rtl/regfile_nrp.sv | 47 ++++
 tb/tb_regfile_nrp.sv | 123 ++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address-width helper for the regfile_nrp register file.
package regfile_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NRD   = 2;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_nrp_muxn_w.sv
// muxn_w: DEPTH:1 binary mux tree of mux2_1 cells; select bit k steers level k (leaves at level 0).
module mux2_1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? b : a;
endmodule

module muxn_w
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] din,
    input  logic [addr_w(DEPTH)-1:0]    sel,
    output logic [WIDTH-1:0]            dout
);
    localparam int AW = addr_w(DEPTH);
    // Heap-indexed tree: node n selects between children 2n and 2n+1, leaves start at DEPTH.
    logic [2*DEPTH-1:1][WIDTH-1:0] node;
    assign node[2*DEPTH-1:DEPTH] = din;
    for (genvar k = 0; k < AW; k++) begin : g_lvl
        for (genvar j = 0; j < (DEPTH >> (k + 1)); j++) begin : g_mux
            localparam int N = (DEPTH >> (k + 1)) + j;
            mux2_1 #(.WIDTH(WIDTH)) u_mux2 (
                .a(node[2*N]),
                .b(node[2*N+1]),
                .s(sel[k]),
                .y(node[N])
            );
        end
    end
    assign dout = node[1];
endmodule

// File: rtl/regfile_nrp.sv
// regfile_nrp: flip-flop register file, NRD combinational read ports, optional hard-wired zero register.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_nrp
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD,
    parameter int ZREG  = DEPTH - 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we,
    input  logic [addr_w(DEPTH)-1:0]           waddr,
    input  logic [WIDTH-1:0]                   wdata,
    input  logic [NRD-1:0][addr_w(DEPTH)-1:0]  raddr,
    output logic [NRD-1:0][WIDTH-1:0]          rdata
);
    localparam int AW = addr_w(DEPTH);
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i == ZREG) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_ff
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk)
                if (!rst_n)
                    q <= '0;
                else if (we && waddr == AW'(i))
                    q <= wdata;
            assign regs[i] = q;
        end
    end
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [WIDTH-1:0] mux_q;
        muxn_w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_muxn (
            .din(regs),
            .sel(raddr[p]),
            .dout(mux_q)
        );
`ifdef REGFILE_BYPASS_EN
        assign rdata[p] = (we && rst_n && waddr == raddr[p] && int'(waddr) != ZREG) ? wdata : mux_q;
`else
        assign rdata[p] = mux_q;
`endif
    end
endmodule

// File: tb/tb_regfile_nrp.sv
// tb_regfile_nrp: directed and random checks of regfile_nrp against an array-based reference model.
module tb_regfile_nrp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, we;
    logic [4:0]       waddr;
    logic [63:0]      wdata;
    logic [1:0][4:0]  raddr;
    logic [1:0][63:0] rdata;

    logic             rst_n2, we2;
    logic [3:0]       waddr2;
    logic [31:0]      wdata2;
    logic [2:0][3:0]  raddr2;
    logic [2:0][31:0] rdata2;

    regfile_nrp u_dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rdata)
    );

    regfile_nrp #(.WIDTH(32), .DEPTH(16), .NRD(3), .ZREG(16)) u_sw (
        .clk(clk), .rst_n(rst_n2), .we(we2), .waddr(waddr2),
        .wdata(wdata2), .raddr(raddr2), .rdata(rdata2)
    );

    logic [63:0] mem  [32];
    logic [31:0] mem2 [16];
    int n_chk = 0;
    int n_ok  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock cycle on the default instance: drive, check reads mid-cycle, then advance the model.
    task automatic cyc(input bit r, input bit w, input int wa, input logic [63:0] wd,
                       input int ra0, input int ra1);
        int ra[2];
        logic [63:0] e;
        ra[0] = ra0;
        ra[1] = ra1;
        rst_n = r; we = w; waddr = 5'(wa); wdata = wd;
        raddr[0] = 5'(ra0); raddr[1] = 5'(ra1);
        #4;
        for (int p = 0; p < 2; p++) begin
            e = (BYP && r && w && wa == ra[p] && wa != 31) ? wd : mem[ra[p]];
            check($sformatf("rd%0d[r%0d]", p, ra[p]), rdata[p], e);
        end
        @(posedge clk);
        if (!r) for (int i = 0; i < 32; i++) mem[i] = '0;
        else if (w && wa != 31) mem[wa] = wd;
        #1;
    endtask

    task automatic cyc2(input bit r, input bit w, input int wa, input logic [31:0] wd,
                        input int ra0, input int ra1, input int ra2);
        int ra[3];
        logic [31:0] e;
        ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
        rst_n2 = r; we2 = w; waddr2 = 4'(wa); wdata2 = wd;
        for (int p = 0; p < 3; p++) raddr2[p] = 4'(ra[p]);
        #4;
        for (int p = 0; p < 3; p++) begin
            e = (BYP && r && w && wa == ra[p]) ? wd : mem2[ra[p]];
            check($sformatf("sw_rd%0d[r%0d]", p, ra[p]), {32'h0, rdata2[p]}, {32'h0, e});
        end
        @(posedge clk);
        if (!r) for (int i = 0; i < 16; i++) mem2[i] = '0;
        else if (w) mem2[wa] = wd;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        rst_n2 = 1'b0; we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem2[i] = '0;
        // Reset clears a written register on every port.
        cyc(1, 1, 5, 64'hDEAD, 5, 5);
        cyc(0, 0, 0, 0, 5, 5);
        cyc(1, 0, 0, 0, 5, 5);
        // Basic write, then both ports read it.
        cyc(1, 1, 3, 64'h0123_4567_89AB_CDEF, 0, 1);
        cyc(1, 0, 0, 0, 3, 3);
        // Zero register ignores writes and never bypasses.
        cyc(1, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
        cyc(1, 0, 0, 0, 31, 31);
        // Same-cycle read-after-write.
        cyc(1, 1, 7, 64'h11, 0, 0);
        cyc(1, 1, 7, 64'h22, 7, 7);
        cyc(1, 0, 0, 0, 7, 3);
        // Write during reset is discarded.
        cyc(0, 1, 4, 64'h55, 4, 3);
        cyc(1, 0, 0, 0, 4, 3);
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(31) != 0, $urandom_range(1), $urandom_range(31),
                {$urandom, $urandom}, $urandom_range(31), $urandom_range(31));

        // Parameter sweep instance: no zero register, three ports.
        cyc2(1, 1, 15, 32'hA5A5_A5A5, 15, 0, 1);
        cyc2(1, 0, 0, 0, 15, 15, 15);
        cyc2(1, 1, 15, 32'h5A5A_0F0F, 15, 15, 3);
        cyc2(0, 1, 2, 32'h1234, 15, 2, 2);
        cyc2(1, 0, 0, 0, 15, 2, 0);
        for (int n = 0; n < 200; n++)
            cyc2($urandom_range(31) != 0, $urandom_range(1), $urandom_range(15), $urandom,
                 $urandom_range(15), $urandom_range(15), $urandom_range(15));

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
